// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-access stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W_DEF      = 32'd16;
  localparam int unsigned REG_W_DEF       = 32'd3;
  localparam int unsigned ADDR_W_DEF      = 32'd8;
  localparam int unsigned WAIT_CYCLES_DEF = 32'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // The counter only ever holds WAIT_CYCLES-1 down to 0.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles > 32'd1) ? $clog2(wait_cycles) : 32'd1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES_DEF);

endpackage

// File: rtl/data_mem.sv
// Word-addressed data RAM: synchronous write, combinational read.
module data_mem #(
  parameter int unsigned DATA_W = 32'd16,
  parameter int unsigned ADDR_W = 32'd8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: loads/stores against data_mem and drives MEM/WB.
// Define MEM_WAIT_EN to build the multi-cycle access FSM that drives Stall.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned REG_W       = REG_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  Rd3In,
  input  logic              RegWrIn,
  input  logic              MemRIn,
  input  logic              MemWIn,
  input  logic              WBIn,
  input  logic [DATA_W-1:0] DataInIn,
  input  logic [DATA_W-1:0] ALUOutIn,
  output logic              Stall,
  output logic [REG_W-1:0]  Rd4Out,
  output logic              RegWrOut,
  output logic [DATA_W-1:0] WBDataOut
);

  logic [REG_W-1:0]  rd_s;
  logic              regwr_s;
  logic              memw_s;
  logic              wb_s;
  logic [DATA_W-1:0] din_s;
  logic [DATA_W-1:0] alu_s;
  logic              complete_s;
  logic              bubble_s;
  logic              stall_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] rdata_s;
  logic              unused_s;

  logic [REG_W-1:0]  rd4_q, rd4_d;
  logic              regwr_q, regwr_d;
  logic [DATA_W-1:0] wbdata_q, wbdata_d;

`ifdef MEM_WAIT_EN
  localparam int unsigned CNT_W_L = cnt_width(WAIT_CYCLES);
  localparam bit          WAIT_ON = (WAIT_CYCLES != 32'd0);

  state_e              state_q, state_d;
  logic [CNT_W_L-1:0]  cnt_q, cnt_d;
  logic [REG_W-1:0]    lat_rd_q, lat_rd_d;
  logic                lat_regwr_q, lat_regwr_d;
  logic                lat_memw_q, lat_memw_d;
  logic                lat_wb_q, lat_wb_d;
  logic [DATA_W-1:0]   lat_din_q, lat_din_d;
  logic [DATA_W-1:0]   lat_alu_q, lat_alu_d;

  // Wait-state FSM: latch a memory op, count it out, then complete from the latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_rd_d    = lat_rd_q;
    lat_regwr_d = lat_regwr_q;
    lat_memw_d  = lat_memw_q;
    lat_wb_d    = lat_wb_q;
    lat_din_d   = lat_din_q;
    lat_alu_d   = lat_alu_q;
    rd_s        = Rd3In;
    regwr_s     = RegWrIn;
    memw_s      = MemWIn;
    wb_s        = WBIn;
    din_s       = DataInIn;
    alu_s       = ALUOutIn;
    stall_s     = 1'b0;
    complete_s  = 1'b0;
    bubble_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((MemRIn || MemWIn) && WAIT_ON) begin
          lat_rd_d    = Rd3In;
          lat_regwr_d = RegWrIn;
          lat_memw_d  = MemWIn;
          lat_wb_d    = WBIn;
          lat_din_d   = DataInIn;
          lat_alu_d   = ALUOutIn;
          cnt_d       = CNT_W_L'(WAIT_CYCLES - 32'd1);
          state_d     = BUSY;
          bubble_s    = 1'b1;
          stall_s     = 1'b1;
        end else begin
          complete_s  = 1'b1;
        end
      end
      BUSY: begin
        rd_s    = lat_rd_q;
        regwr_s = lat_regwr_q;
        memw_s  = lat_memw_q;
        wb_s    = lat_wb_q;
        din_s   = lat_din_q;
        alu_s   = lat_alu_q;
        if (cnt_q != {CNT_W_L{1'b0}}) begin
          cnt_d    = cnt_q - CNT_W_L'(1'b1);
          stall_s  = 1'b1;
          bubble_s = 1'b1;
        end else begin
          complete_s = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, counter and input latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W_L{1'b0}};
      lat_rd_q    <= {REG_W{1'b0}};
      lat_regwr_q <= 1'b0;
      lat_memw_q  <= 1'b0;
      lat_wb_q    <= 1'b0;
      lat_din_q   <= {DATA_W{1'b0}};
      lat_alu_q   <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_rd_q    <= lat_rd_d;
      lat_regwr_q <= lat_regwr_d;
      lat_memw_q  <= lat_memw_d;
      lat_wb_q    <= lat_wb_d;
      lat_din_q   <= lat_din_d;
      lat_alu_q   <= lat_alu_d;
    end
  end

  assign unused_s = ^{ALUOutIn[DATA_W-1:ADDR_W], MemRIn};
`else
  // Single-cycle build: every instruction completes straight from the inputs.
  always_comb begin
    rd_s       = Rd3In;
    regwr_s    = RegWrIn;
    memw_s     = MemWIn;
    wb_s       = WBIn;
    din_s      = DataInIn;
    alu_s      = ALUOutIn;
    stall_s    = 1'b0;
    complete_s = 1'b1;
    bubble_s   = 1'b0;
  end

  assign unused_s = ^{ALUOutIn[DATA_W-1:ADDR_W], MemRIn, WAIT_CYCLES[0]};
`endif

  // A store in flight when rst rises must never reach the array.
  assign mem_we_s = complete_s & memw_s & ~rst;
  assign Stall    = stall_s & ~rst;

  data_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (alu_s[ADDR_W-1:0]),
    .wdata (din_s),
    .raddr (alu_s[ADDR_W-1:0]),
    .rdata (rdata_s)
  );

  // MEM/WB next value: bubble, completed result, or hold.
  always_comb begin
    rd4_d    = rd4_q;
    regwr_d  = regwr_q;
    wbdata_d = wbdata_q;
    if (bubble_s) begin
      rd4_d    = {REG_W{1'b0}};
      regwr_d  = 1'b0;
      wbdata_d = {DATA_W{1'b0}};
    end else if (complete_s) begin
      rd4_d    = rd_s;
      regwr_d  = regwr_s;
      wbdata_d = wb_s ? rdata_s : alu_s;
    end else begin
      rd4_d    = rd4_q;
      regwr_d  = regwr_q;
      wbdata_d = wbdata_q;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd4_q    <= {REG_W{1'b0}};
      regwr_q  <= 1'b0;
      wbdata_q <= {DATA_W{1'b0}};
    end else begin
      rd4_q    <= rd4_d;
      regwr_q  <= regwr_d;
      wbdata_q <= wbdata_d;
    end
  end

  assign Rd4Out    = rd4_q;
  assign RegWrOut  = regwr_q;
  assign WBDataOut = wbdata_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipelined processor. It sits directly downstream of the EXE/MEM pipeline register and consumes its outputs. It performs data-memory loads and stores against an internal word-addressed RAM and selects the write-back value. It drives the MEM/WB register outputs and, optionally, a stall to freeze upstream stages during multi-cycle memory accesses.

## Interface
- DATA_W, 16, datapath and memory word width
- REG_W, 3, destination register index width
- ADDR_W, 8, memory word-address width; depth = 2**ADDR_W
- WAIT_CYCLES, 2, extra cycles per memory access; used only with MEM_WAIT_EN; 0 behaves as disabled
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Rd3In  in  REG_W  destination register from EXE/MEM
- RegWrIn  in  1  register-write enable from EXE/MEM
- MemRIn  in  1  load request
- MemWIn  in  1  store request
- WBIn  in  1  write-back select: 1 = memory read data, 0 = ALU result
- DataInIn  in  DATA_W  store data
- ALUOutIn  in  DATA_W  ALU result; low ADDR_W bits form the memory address
- Stall  out  1  combinational; upstream must hold all inputs stable while it is 1
- Rd4Out  out  REG_W  destination register to WB
- RegWrOut  out  1  register-write enable to WB
- WBDataOut  out  DATA_W  value to write back

## Operation
- Address = ALUOutIn[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap modulo depth.
- Store:
  - Memory is written at the edge ending the completing cycle.
  - If MemRIn and MemWIn are both 1, the instruction is a store. WBDataOut then takes the pre-write memory word if WBIn=1.
- Load: memory is read combinationally in the completing cycle and registered into WBDataOut.
- Completion edge updates: Rd4Out<=Rd3, RegWrOut<=RegWr, WBDataOut<=(WB ? mem[addr] : ALUOut).
- Non-memory instructions (MemR=MemW=0) always complete in the cycle they are presented. They never stall.
- FSM (MEM_WAIT_EN only), states IDLE and BUSY:
  - IDLE, memory op presented:
    - Latch all inputs and set cnt<=WAIT_CYCLES-1.
    - Go to BUSY.
    - Load a bubble into MEM/WB: RegWrOut<=0, Rd4Out<=0, WBDataOut<=0.
    - Stall=1.
  - BUSY, cnt!=0: Stall=1, cnt<=cnt-1. Inputs are ignored.
  - BUSY, cnt==0:
    - Stall=0.
    - Complete the latched instruction: access memory and load MEM/WB.
    - Go to IDLE.
    - Upstream advances at this same edge.
- rst: state<=IDLE, cnt<=0, Rd4Out<=0, RegWrOut<=0, WBDataOut<=0.
  - Memory contents are not reset.
  - Reset during BUSY aborts the pending access; a pending store is not written.
  - Stall=0 while rst=1.

## Timing
- Without MEM_WAIT_EN: every instruction reaches the MEM/WB outputs one edge after presentation. Stall is constant 0.
- With MEM_WAIT_EN:
  - A memory op occupies WAIT_CYCLES+1 cycles and Stall is high for exactly WAIT_CYCLES consecutive cycles.
  - Results appear at the edge ending the last cycle.
- Back-to-back memory ops: the second is accepted in the cycle after the first completes, with no idle gap.
- Store at edge k followed by a load of the same address presented after edge k: the load returns the new data.

## Configuration
- MEM_WAIT_EN defined: the IDLE/BUSY FSM, wait counter and input latch are compiled in, and Stall is driven as above.
- MEM_WAIT_EN undefined: the FSM, counter and latch are removed, Stall is tied 0, and all accesses are single-cycle.

## Structure
- Shared package mem_stage_pkg holds:
  - DATA_W, REG_W and ADDR_W defaults
  - the state enum (IDLE, BUSY)
  - the counter width constant, sized from WAIT_CYCLES
- One sub-module, data_mem: 2**ADDR_W x DATA_W array with synchronous write (we, waddr, wdata) and combinational read (raddr, rdata). mem_stage instantiates it once.

## Test plan
- Reset, then ALU op with Rd3In=5, RegWrIn=1, WBIn=0, ALUOutIn=0x1234 -> next edge: Rd4Out=5, RegWrOut=1, WBDataOut=0x1234, Stall=0.
- Store DataInIn=0xBEEF at ALUOutIn=0x0010, then load with WBIn=1 from ALUOutIn=0x0110 (wrap) -> WBDataOut=0xBEEF.
- MEM_WAIT_EN with WAIT_CYCLES=2, load presented -> Stall=1 for 2 cycles, bubble on outputs (RegWrOut=0) during them, load result at the 3rd edge.
- MemRIn=MemWIn=1, DataInIn=0x00AA, address 0x20 previously 0x0055, WBIn=1 -> WBDataOut=0x0055, and a later load returns 0x00AA.
- rst asserted in BUSY during a store to address 0x30 (held 0x1111) -> outputs zero and Stall=0 next cycle, state IDLE, and a later load of 0x30 returns 0x1111.
